// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and the countdown width.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101,
    MDU_MADD  = 3'b110,
    MDU_RSVD  = 3'b111
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;
  localparam int MDU_CNT_W           = 4;

  // Two's-complement negate when neg is set; used for magnitude/sign fix-up.
  function automatic logic [31:0] mdu_mag(input logic [31:0] x, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - x;
    end else begin
      r = x;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to enable the madd op (MDUOp 110).
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
  localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);
  localparam logic [MDU_CNT_W-1:0] CNT_ONE  = MDU_CNT_W'(1);
  localparam logic [MDU_CNT_W-1:0] CNT_ZERO = MDU_CNT_W'(0);

  mdu_state_e           state_r;
  logic                 busy_r;
  logic [MDU_CNT_W-1:0] count_r;
  logic [31:0]          hi_r;
  logic [31:0]          lo_r;
  logic [31:0]          shadow_hi_r;
  logic [31:0]          shadow_lo_r;

  logic                 signed_s;
  logic [63:0]          mul_a_s;
  logic [63:0]          mul_b_s;
  logic [63:0]          prod_s;
  logic                 a_neg_s;
  logic                 b_neg_s;
  logic [31:0]          div_n_s;
  logic [31:0]          div_d_s;
  logic [31:0]          quot_mag_s;
  logic [31:0]          rem_mag_s;
  logic [31:0]          quot_s;
  logic [31:0]          rem_s;
  logic                 launch_s;
  logic [MDU_CNT_W-1:0] launch_cnt_s;
  logic [63:0]          launch_res_s;

  assign signed_s = (MDUOp == MDU_MULT) || (MDUOp == MDU_DIV) || (MDUOp == MDU_MADD);

  // One 64-bit multiplier serves both signednesses: the low 64 bits of a
  // product of sign- or zero-extended operands are exact either way.
  assign mul_a_s = {{32{signed_s & A[31]}}, A};
  assign mul_b_s = {{32{signed_s & B[31]}}, B};
  assign prod_s  = mul_a_s * mul_b_s;

  // Shared unsigned divider on magnitudes; signs restored afterwards so the
  // quotient truncates toward zero and the remainder follows the dividend.
  assign a_neg_s    = signed_s & A[31];
  assign b_neg_s    = signed_s & B[31];
  assign div_n_s    = mdu_mag(A, a_neg_s);
  assign div_d_s    = (B == 32'd0) ? 32'd1 : mdu_mag(B, b_neg_s);
  assign quot_mag_s = div_n_s / div_d_s;
  assign rem_mag_s  = div_n_s % div_d_s;
  assign quot_s     = mdu_mag(quot_mag_s, a_neg_s ^ b_neg_s);
  assign rem_s      = mdu_mag(rem_mag_s, a_neg_s);

`ifdef MDU_MADD_EN
  logic [63:0] madd_sum_s;
  assign madd_sum_s = {hi_r, lo_r} + prod_s;
`endif

  // Decode which ops launch a multi-cycle run, its length and its result.
  always_comb begin
    launch_s     = 1'b0;
    launch_cnt_s = MULT_CNT;
    launch_res_s = {hi_r, lo_r};
    case (MDUOp)
      MDU_MULT, MDU_MULTU: begin
        launch_s     = 1'b1;
        launch_cnt_s = MULT_CNT;
        launch_res_s = prod_s;
      end
      MDU_DIV, MDU_DIVU: begin
        launch_s     = 1'b1;
        launch_cnt_s = DIV_CNT;
        if (B != 32'd0) begin
          launch_res_s = {rem_s, quot_s};
        end else begin
          launch_res_s = {hi_r, lo_r};
        end
      end
`ifdef MDU_MADD_EN
      MDU_MADD: begin
        launch_s     = 1'b1;
        launch_cnt_s = MULT_CNT;
        launch_res_s = madd_sum_s;
      end
`endif
      default: begin
        launch_s     = 1'b0;
        launch_cnt_s = MULT_CNT;
        launch_res_s = {hi_r, lo_r};
      end
    endcase
  end

  // Control FSM: accept in IDLE, count down in RUN, commit shadow at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= MDU_IDLE;
      busy_r      <= 1'b0;
      count_r     <= CNT_ZERO;
      hi_r        <= 32'd0;
      lo_r        <= 32'd0;
      shadow_hi_r <= 32'd0;
      shadow_lo_r <= 32'd0;
    end else begin
      case (state_r)
        MDU_IDLE: begin
          if (start) begin
            if (launch_s) begin
              shadow_hi_r <= launch_res_s[63:32];
              shadow_lo_r <= launch_res_s[31:0];
              count_r     <= launch_cnt_s;
              busy_r      <= 1'b1;
              state_r     <= MDU_RUN;
            end else if (MDUOp == MDU_MTHI) begin
              hi_r <= A;
            end else if (MDUOp == MDU_MTLO) begin
              lo_r <= A;
            end
          end
        end
        MDU_RUN: begin
          count_r <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            hi_r    <= shadow_hi_r;
            lo_r    <= shadow_lo_r;
            busy_r  <= 1'b0;
            state_r <= MDU_IDLE;
          end
        end
        default: begin
          state_r <= MDU_IDLE;
          busy_r  <= 1'b0;
          count_r <= CNT_ZERO;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule
